// File: rtl/task3_stim_checker.sv
// Stimulus source and scoreboard for the task_3 two-flop register block.
// Optional macro STIM_LOOP_EN adds a 'loop' input for continuous soak runs.
module task3_stim_checker #(
  parameter int          NUM_VEC   = 8,
  parameter logic [63:0] VEC_TABLE = 64'h0000_0000_8421_F1C3
) (
  input  logic       clk,
  input  logic       preset0,
  input  logic       start,
`ifdef STIM_LOOP_EN
  input  logic       loop,
`endif
  input  logic       op0,
  input  logic       op1,
  input  logic       op2,
  output logic       ip0,
  output logic       ip1,
  output logic       ip2,
  output logic       ip3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] first_fail_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [3:0] LAST_IDX = 4'(NUM_VEC - 1);

  state_t     state, next_state;
  logic [3:0] idx;
  logic [3:0] ip_reg;
  logic       s1_valid, s2_valid;
  logic [2:0] s1_exp, s2_exp;
  logic [3:0] s1_idx, s2_idx;

  logic       launch, drive, last_vec, mismatch, finish, loop_on;
  logic [3:0] drive_idx;
  logic [7:0] err_next;
  logic [3:0] ffi_next;

  function automatic logic [3:0] vec_at(input logic [3:0] k);
    return VEC_TABLE[{k, 2'b00} +: 4];
  endfunction

  // Expected response packed as {op2, op1, op0}.
  function automatic logic [2:0] expect_of(input logic [3:0] v);
    logic e0, e1;
    e0 = v[0] & v[1];
    e1 = ~(v[2] | v[3]);
    return {~(e0 & e1), e1, e0};
  endfunction

`ifdef STIM_LOOP_EN
  assign loop_on = loop;
`else
  assign loop_on = 1'b0;
`endif

  assign launch    = ((state == IDLE) || (state == DONE)) && start;
  assign drive     = launch || (state == RUN);
  assign drive_idx = launch ? 4'd0 : idx;
  assign last_vec  = (drive_idx == LAST_IDX);
  assign mismatch  = s2_valid && ({op2, op1, op0} != s2_exp);
  // Last compare: stage 2 holds the final vector and nothing follows it.
  assign finish    = (state == DRAIN) && s2_valid && !s1_valid;

  assign {ip3, ip2, ip1, ip0} = ip_reg;

  always_ff @(posedge clk or negedge preset0) begin
    if (!preset0) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start) next_state = (last_vec && !loop_on) ? DRAIN : RUN;
      RUN:        if (last_vec && !loop_on) next_state = DRAIN;
      DRAIN:      if (finish) next_state = DONE;
      default:    next_state = IDLE;
    endcase
  end

  always_comb begin
    err_next = err_count;
    ffi_next = first_fail_idx;
    if (launch) begin
      err_next = 8'd0;
      ffi_next = 4'hF;
    end else if (mismatch) begin
      if (err_count != 8'hFF) err_next = err_count + 8'd1;
      if (first_fail_idx == 4'hF) ffi_next = s2_idx;
    end
  end

  // Stimulus register plus the two-stage expected-value pipeline that
  // lines each vector up with the DUT's one-cycle register latency.
  always_ff @(posedge clk or negedge preset0) begin
    if (!preset0) begin
      ip_reg         <= 4'd0;
      idx            <= 4'd0;
      s1_valid       <= 1'b0;
      s1_exp         <= 3'd0;
      s1_idx         <= 4'd0;
      s2_valid       <= 1'b0;
      s2_exp         <= 3'd0;
      s2_idx         <= 4'd0;
      err_count      <= 8'd0;
      first_fail_idx <= 4'hF;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
    end else begin
      if (drive) begin
        ip_reg   <= vec_at(drive_idx);
        idx      <= last_vec ? 4'd0 : drive_idx + 4'd1;
        s1_valid <= 1'b1;
        s1_exp   <= expect_of(vec_at(drive_idx));
        s1_idx   <= drive_idx;
      end else begin
        s1_valid <= 1'b0;
      end
      s2_valid       <= s1_valid;
      s2_exp         <= s1_exp;
      s2_idx         <= s1_idx;
      err_count      <= err_next;
      first_fail_idx <= ffi_next;
      if (launch) begin
        busy <= 1'b1;
        done <= 1'b0;
        pass <= 1'b0;
      end else if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (err_next == 8'd0);
      end
    end
  end

endmodule

// File: tb/tb_task3_stim_checker.sv
// Scoreboard bench for task3_stim_checker driving a behavioural task_3 model
// with selectable output faults.
module tb_task3_stim_checker;

  localparam int NUM_VEC = 8;

  logic       clk = 1'b0;
  logic       preset0 = 1'b0;
  logic       start = 1'b0;
  logic       op0, op1, op2;
  logic       ip0, ip1, ip2, ip3;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] first_fail_idx;
`ifdef STIM_LOOP_EN
  logic       loop = 1'b0;
`endif

  int fault_mode = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] err;
    logic [3:0] ffi;
    logic       pass;
    int         lat;
  } result_t;

  logic [3:0] exp_ip_q[$];
  result_t    exp_res_q[$];
  logic [3:0] vec_tbl [8] = '{4'h3, 4'hC, 4'h1, 4'hF, 4'h1, 4'h2, 4'h4, 4'h8};

  task3_stim_checker dut (
    .clk(clk), .preset0(preset0), .start(start),
`ifdef STIM_LOOP_EN
    .loop(loop),
`endif
    .op0(op0), .op1(op1), .op2(op2),
    .ip0(ip0), .ip1(ip1), .ip2(ip2), .ip3(ip3),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_idx(first_fail_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural task_3 block; fault 1 = op1 stuck-at-0, fault 2 = op0 inverted.
  logic r0 = 1'b0, r1 = 1'b0;
  always @(posedge clk) begin
    r0 <= ip0 & ip1;
    r1 <= ~(ip2 | ip3);
  end
  assign op0 = (fault_mode == 2) ? ~r0 : r0;
  assign op1 = (fault_mode == 1) ? 1'b0 : r1;
  assign op2 = ~(r0 & r1);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int fault, input logic [7:0] err, input logic [3:0] ffi,
                               input logic ps, input int lat);
    result_t r;
    fault_mode = fault;
    for (int k = 0; k < NUM_VEC; k++) exp_ip_q.push_back(vec_tbl[k]);
    r.err = err; r.ffi = ffi; r.pass = ps; r.lat = lat;
    exp_res_q.push_back(r);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done) break;
    end
    checkOutput("done_seen", {31'd0, done}, 32'd1);
    @(negedge clk);
  endtask

  // Monitor: pops expected stimulus while a run is driving, and the expected
  // result record when done rises.
  logic    prev_busy = 1'b0, prev_done = 1'b0;
  int      launch_cyc = 0;
  result_t mr;
  logic [3:0] me;
  always @(negedge clk) begin
    if (!preset0) begin
      prev_busy = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (busy && !prev_busy) launch_cyc = cyc;
      if (busy && (cyc - launch_cyc) < NUM_VEC) begin
        if (exp_ip_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL ip_unexpected actual=%0h expected=none", {ip3, ip2, ip1, ip0});
        end else begin
          me = exp_ip_q.pop_front();
          checkOutput($sformatf("ip_vec%0d", cyc - launch_cyc), {28'd0, ip3, ip2, ip1, ip0}, {28'd0, me});
        end
      end
      if (done && !prev_done) begin
        if (exp_res_q.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL done_unexpected actual=1 expected=0");
        end else begin
          mr = exp_res_q.pop_front();
          checkOutput("err_count", {24'd0, err_count}, {24'd0, mr.err});
          checkOutput("first_fail_idx", {28'd0, first_fail_idx}, {28'd0, mr.ffi});
          checkOutput("pass", {31'd0, pass}, {31'd0, mr.pass});
          if (mr.lat >= 0) checkOutput("done_latency", cyc - launch_cyc, mr.lat);
        end
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ip"}, {28'd0, ip3, ip2, ip1, ip0}, 32'd0);
    checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, "_pass"}, {31'd0, pass}, 32'd0);
    checkOutput({tag, "_err"}, {24'd0, err_count}, 32'd0);
    checkOutput({tag, "_ffi"}, {28'd0, first_fail_idx}, 32'hF);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkResetValues("rst");
    preset0 = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] clean run");
    applyStimulus(0, 8'd0, 4'hF, 1'b1, 9);
    waitDone(30);

    $display("[TB] op1 stuck-at-0");
    applyStimulus(1, 8'd4, 4'h0, 1'b0, 9);
    waitDone(30);

    $display("[TB] op0 inverted");
    applyStimulus(2, 8'd8, 4'h0, 1'b0, 9);
    waitDone(30);

    $display("[TB] start re-pulsed mid-run");
    applyStimulus(1, 8'd4, 4'h0, 1'b0, 9);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(30);

    $display("[TB] reset mid-run");
    applyStimulus(1, 8'd4, 4'h0, 1'b0, 9);
    repeat (4) @(posedge clk);
    #1 preset0 = 1'b0;
    #1 checkResetValues("abort");
    #18 preset0 = 1'b1;
    exp_ip_q.delete();
    exp_res_q.delete();
    applyStimulus(0, 8'd0, 4'hF, 1'b1, 9);
    waitDone(30);

`ifdef STIM_LOOP_EN
    $display("[TB] loop soak");
    loop = 1'b1;
    applyStimulus(1, 8'd255, 4'h0, 1'b0, -1);
    repeat (70 * NUM_VEC) @(negedge clk);
    checkOutput("loop_err_sat", {24'd0, err_count}, 32'd255);
    checkOutput("loop_done_low", {31'd0, done}, 32'd0);
    checkOutput("loop_busy", {31'd0, busy}, 32'd1);
    loop = 1'b0;
    waitDone(2 * NUM_VEC + 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
